hazard_sequencer: RTL

- Central stall/flush controller for the 5-stage 16-bit pipeline.
- Turns level hazard indications from ID-stage detection (load-to-use, Branch (BR), Branch (B), mispredict) and cache miss levels into per-stage stall/flush controls.
- Arbitrates the single shared main memory between I-cache and D-cache fills.
- On HLT, freezes fetch, drains the pipeline and raises halted.

---
 rtl/hazard_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hazard_sequencer.sv
// Central stall/flush controller for the 5-stage 16-bit pipeline: hazard steering,
// I/D-cache fill arbitration for the shared main memory, and HLT drain/halt.
module hazard_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hazard,
  input  logic             br_hazard,
  input  logic             b_hazard,
  input  logic             mispredict,
  input  logic             hlt_id,
  input  logic             icache_miss,
  input  logic             dcache_miss,
  input  logic             fill_done,
  output logic             fill_req,
  output logic             fill_sel,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {MODE_RUN, MODE_DRAIN, MODE_HALTED} mode_t;
  typedef enum logic [1:0] {FILL_IDLE, FILL_I, FILL_D} fill_t;

  mode_t         mode_q, mode_d;
  fill_t         fill_q, fill_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          hazard;
  logic          run;

  assign hazard = load_use_hazard | br_hazard | b_hazard;
  assign run    = (mode_q == MODE_RUN);

  // A pending D-miss freezes everything up to MEM and overrides all other sources.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_flush     = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (dcache_miss) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (run) begin
      if (hazard) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (mispredict) begin
        if_flush = 1'b1;
      end else if (icache_miss || hlt_id) begin
        pc_stall = 1'b1;
        if_flush = 1'b1;
      end
    end else begin
      pc_stall = 1'b1;
      if_flush = 1'b1;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    drain_d = drain_q;
    case (mode_q)
      MODE_RUN: begin
        if (!dcache_miss && !hazard && !mispredict && !icache_miss && hlt_id) begin
          mode_d  = MODE_DRAIN;
          drain_d = DW'(DRAIN_CYCLES);
        end
      end
      MODE_DRAIN: begin
        if (!dcache_miss) begin
          if (drain_q <= DW'(1)) begin
            drain_d = '0;
            mode_d  = MODE_HALTED;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
      end
      MODE_HALTED: mode_d = MODE_HALTED;
      default:     mode_d = MODE_RUN;
    endcase
  end

  // Fills run to completion; on fill_done only the opposite side's miss is considered.
  always_comb begin
    fill_d = fill_q;
    case (fill_q)
      FILL_IDLE: begin
        if (dcache_miss)              fill_d = FILL_D;
        else if (icache_miss && run)  fill_d = FILL_I;
      end
      FILL_I: begin
        if (fill_done) fill_d = dcache_miss ? FILL_D : FILL_IDLE;
      end
      FILL_D: begin
        if (fill_done) fill_d = (icache_miss && run) ? FILL_I : FILL_IDLE;
      end
      default: fill_d = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_RUN;
      fill_q   <= FILL_IDLE;
      drain_q  <= '0;
      fill_req <= 1'b0;
      fill_sel <= 1'b0;
      halted   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      drain_q  <= drain_d;
      fill_req <= (fill_d != FILL_IDLE);
      fill_sel <= (fill_d == FILL_D);
      halted   <= (mode_d == MODE_HALTED);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (run) begin
      if (pc_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((if_flush || id_ex_flush) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
